bus_bridge: RTL
===============

Name: bus_bridge

Overview:
- Sits directly downstream of the CPU core's MEM stage.
- Decodes the core's Bus_addr and steers word reads and writes to either the data RAM or the on-board peripherals: LEDs, switches, buttons, 8-digit seven-segment display, and an optional timer.
- Owns all peripheral state.
- Returns read data combinationally in the same cycle, because the core latches Bus_rdata into MEM/WB at the next edge.

Parameters:
- DRAM_AW, 14: word-address width driven to the data RAM.
- SCAN_DIV, 20000: cpu_clk cycles per display digit slot; must be ≥2.
- PERIPH_BASE, 32'hFFFF_F000: base of the 4 KiB peripheral page.

Ports:
- cpu_clk  input  1  system clock; all state updates on the rising edge.
- cpu_rst  input  1  asynchronous, active-low reset.
- Bus_addr  input  32  byte address from the core MEM stage.
- Bus_rdata  output  32  read data to the core; combinational.
- Bus_wen  input  1  word write enable from the core.
- Bus_wdata  input  32  write data from the core.
- dram_addr  output  DRAM_AW  data RAM word address = Bus_addr[DRAM_AW+1:2].
- dram_wen  output  1  data RAM write enable.
- dram_wdata  output  32  data RAM write data = Bus_wdata.
- dram_rdata  input  32  data RAM asynchronous read data.
- sw  input  24  board switches, asynchronous to cpu_clk.
- button  input  5  board buttons, asynchronous to cpu_clk.
- led  output  24  LED register.
- dig_en  output  8  digit enables, active-low, one-hot-zero.
- dig_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Decode: peripheral hit when Bus_addr[31:12] == PERIPH_BASE[31:12]; otherwise DRAM hit.
- Offsets are Bus_addr[11:0] with bits [1:0] ignored (word access only):
  - 0x000 DIG, RW.
  - 0x020 TIMER, RW, optional.
  - 0x060 LED, RW.
  - 0x070 SW, RO.
  - 0x078 BTN, RO.
- dram_wen = Bus_wen & DRAM hit. Peripheral-page writes never reach the RAM.
- Read mux, combinational:
  - DRAM hit → dram_rdata.
  - DIG → digit register.
  - LED → {8'h0, led}.
  - SW → {8'h0, sw_sync}.
  - BTN → {27'h0, btn_sync}.
  - TIMER → timer value, or 0 when the timer is compiled out.
  - Any unmapped peripheral offset → 32'h0.
- Writes: take effect at the rising edge where Bus_wen=1 and the decode matches. The new value is readable the following cycle.
  - Writes to SW, BTN, or unmapped offsets are ignored.
  - LED takes Bus_wdata[23:0].
  - DIG takes all 32 bits.
- Input sync: sw and button each pass through a 2-flop synchronizer, reset to 0. Read latency from a pin change to a visible value is 2 cycles.
- Display scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - When the prescaler reaches SCAN_DIV-1, the 3-bit digit index increments, wrapping 7→0.
  - dig_en = ~(8'b1 << idx), registered.
  - dig_seg = active-low hex decode of DIG[4*idx+3:4*idx], registered, with dp=1 (off).
  - Decode table: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- A DIG write mid-scan shows on the next registered update; the scan position does not restart.
- Reset (cpu_rst=0, asynchronous):
  - led=0, DIG=0, sync flops=0, prescaler=0, idx=0, timer=0.
  - dig_en=8'hFE, dig_seg=8'hC0.
  - Bus_rdata, dram_* follow their combinational definitions.
- Releasing reset mid-scan restarts scanning at digit 0.

Optional Feature:
- Macro BRIDGE_TIMER_EN.
- Defined:
  - 32-bit TIMER register increments by 1 every cycle and wraps FFFF_FFFF→0.
  - A write at TIMER loads Bus_wdata. On the same-edge increment/write collision, the write wins; the loaded value increments on the next edge.
  - Reads return the current value.
- Undefined: no timer logic; TIMER reads 0 and writes are ignored.

Test Plan:
- Reset held low 3 cycles, then released → led=0, dig_en=FE, dig_seg=C0, read of LED returns 0. After SCAN_DIV cycles, dig_en=FD.
- Bus_addr=0000_0104, Bus_wen=1, wdata=DEAD_BEEF → dram_wen=1, dram_addr=0x041. Read with dram_rdata=1234_5678 → Bus_rdata=1234_5678.
- Write FFFF_F060 ← 00AB_CDEF → led=AB_CDEF next cycle, dram_wen=0. Write FFFF_F070 ← FFFF_FFFF → no effect. Read FFFF_F040 → 0.
- sw=24'h00_0055 applied → read FFFF_F070 returns 0 for 2 cycles, then 0000_0055. button=5'b10001 → BTN read 0000_0011.
- DIG ← 8765_4321, SCAN_DIV=4 → idx0 seg=F9 en=FE, idx1 seg=A4 en=FD, …, idx7 seg=80 en=7F, then wraps to idx0.
- BRIDGE_TIMER_EN: write TIMER ← FFFF_FFFE → reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on consecutive cycles. Without the macro, reads are 0.

Source files
------------

// File: rtl/bus_bridge_if.sv
// Core-side word bus between the MEM stage and bus_bridge.
// The core drives the master side; the bridge answers on the slave side with same-cycle read data.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic [31:0] Bus_rdata;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;

  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/bus_bridge.sv
// Address decoder and peripheral block behind the core MEM stage: data RAM steering, LEDs,
// switches, buttons, a scanned 8-digit seven-segment display and an optional timer (BRIDGE_TIMER_EN).
module bus_bridge #(
  parameter int unsigned DRAM_AW     = 14,
  parameter int unsigned SCAN_DIV    = 20000,
  parameter logic [31:0] PERIPH_BASE = 32'hFFFF_F000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  bus_bridge_if.slave        bus,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam int unsigned      PresW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(SCAN_DIV - 1);

  // Word offsets within the peripheral page (byte offset >> 2).
  localparam logic [9:0] OffDig   = 10'h000;
  localparam logic [9:0] OffTimer = 10'h008;
  localparam logic [9:0] OffLed   = 10'h018;
  localparam logic [9:0] OffSw    = 10'h01C;
  localparam logic [9:0] OffBtn   = 10'h01E;

  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_of = 8'hC0;
      4'h1:    seg_of = 8'hF9;
      4'h2:    seg_of = 8'hA4;
      4'h3:    seg_of = 8'hB0;
      4'h4:    seg_of = 8'h99;
      4'h5:    seg_of = 8'h92;
      4'h6:    seg_of = 8'h82;
      4'h7:    seg_of = 8'hF8;
      4'h8:    seg_of = 8'h80;
      4'h9:    seg_of = 8'h90;
      4'hA:    seg_of = 8'h88;
      4'hB:    seg_of = 8'h83;
      4'hC:    seg_of = 8'hC6;
      4'hD:    seg_of = 8'hA1;
      4'hE:    seg_of = 8'h86;
      default: seg_of = 8'h8E;
    endcase
  endfunction

  logic             periph_hit;
  logic [9:0]       word_off;
  logic             periph_wr;
  logic             unused_addr;

  logic [23:0]      led_q;
  logic [31:0]      dig_q;
  logic [23:0]      sw_meta_q, sw_sync_q;
  logic [4:0]       btn_meta_q, btn_sync_q;
  logic [PresW-1:0] presc_q;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dig_en_q, dig_seg_q;
  logic [31:0]      timer_val;

  assign periph_hit  = (bus.Bus_addr[31:12] == PERIPH_BASE[31:12]);
  assign word_off    = bus.Bus_addr[11:2];
  assign periph_wr   = bus.Bus_wen & periph_hit;
  assign unused_addr = ^bus.Bus_addr[1:0];

  assign dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = bus.Bus_wen & ~periph_hit;
  assign dram_wdata = bus.Bus_wdata;

  assign led     = led_q;
  assign dig_en  = dig_en_q;
  assign dig_seg = dig_seg_q;

  // The digit outputs are registered from the next index so they move on the same edge as idx_q.
  assign idx_d = (presc_q == PresMax) ? idx_q + 3'd1 : idx_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led_q      <= '0;
      dig_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      dig_en_q   <= 8'hFE;
      dig_seg_q  <= 8'hC0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;

      presc_q   <= (presc_q == PresMax) ? '0 : presc_q + 1'b1;
      idx_q     <= idx_d;
      dig_en_q  <= ~(8'b1 << idx_d);
      dig_seg_q <= seg_of(dig_q[{idx_d, 2'b00} +: 4]);

      if (periph_wr && word_off == OffLed) led_q <= bus.Bus_wdata[23:0];
      if (periph_wr && word_off == OffDig) dig_q <= bus.Bus_wdata;
    end
  end

`ifdef BRIDGE_TIMER_EN
  logic [31:0] timer_q;

  // A bus write wins over the free-running increment on the same edge.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      timer_q <= '0;
    end else if (periph_wr && word_off == OffTimer) begin
      timer_q <= bus.Bus_wdata;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  always_comb begin
    bus.Bus_rdata = '0;
    if (!periph_hit) begin
      bus.Bus_rdata = dram_rdata;
    end else begin
      case (word_off)
        OffDig:   bus.Bus_rdata = dig_q;
        OffTimer: bus.Bus_rdata = timer_val;
        OffLed:   bus.Bus_rdata = {8'h0, led_q};
        OffSw:    bus.Bus_rdata = {8'h0, sw_sync_q};
        OffBtn:   bus.Bus_rdata = {27'h0, btn_sync_q};
        default:  bus.Bus_rdata = '0;
      endcase
    end
  end

endmodule
